// File: rtl/udp_rx_dispatch_pkg.sv
// Shared types and constants for the UDP RX channel dispatcher.
package udp_rx_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;
  localparam int HDR_ID_W   = 8;

endpackage

// File: rtl/udp_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module udp_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/udp_rx_dispatch.sv
// Routes a UDP payload stream to one of N_CH channels selected by the first byte.
// Optional idle watchdog enabled by defining UDP_RX_DISPATCH_TIMEOUT_EN.
module udp_rx_dispatch
  import udp_rx_dispatch_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid,
  input  logic                  rx_end,
  input  logic [HDR_ID_W-1:0]   i_data,
  output logic [N_CH-1:0]       ch_valid,
  output logic [N_CH-1:0]       ch_rx_end,
  output logic [7:0]            ch_data,
  output logic                  busy,
  output logic                  err_id,
  output logic                  err_ovf,
  output logic                  err_timeout,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output state_t                state_dbg
);

  // Input handshake: a byte is taken on every cycle valid=1 (no backpressure);
  // rx_end is a single-cycle strobe that may share a cycle with the last byte.

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t          state, state_n;
  logic [CH_W-1:0] sel, sel_n;
  logic [LEN_W-1:0] len, len_n;
  logic            ovf, ovf_n;
  logic [N_CH-1:0] ch_valid_n, ch_rx_end_n;
  logic [7:0]      ch_data_n;
  logic            err_id_n, err_ovf_n, drop_inc;
  logic            id_ok;
  logic            wd_expire;

  assign id_ok     = (i_data < HDR_ID_W'(N_CH));
  assign state_dbg = state;

`ifdef UDP_RX_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_idle;

  // Any input activity restarts the count, so an input event always beats expiry.
  assign wd_idle   = (state != IDLE) && !valid && !rx_end;
  assign wd_expire = wd_idle && (wd_cnt == WD_W'(TIMEOUT - 1));

  udp_sat_cnt #(.W(WD_W)) u_wd_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!wd_idle || wd_expire),
    .inc  (wd_idle),
    .q    (wd_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_timeout <= 1'b0;
    else       err_timeout <= wd_expire;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign wd_expire      = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    len_n       = len;
    ovf_n       = ovf;
    ch_valid_n  = '0;
    ch_rx_end_n = '0;
    ch_data_n   = ch_data;
    err_id_n    = 1'b0;
    err_ovf_n   = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (id_ok) begin
            if (rx_end) begin
              ch_rx_end_n = N_CH'(1) << i_data[CH_W-1:0];
            end else begin
              sel_n   = i_data[CH_W-1:0];
              len_n   = '0;
              state_n = ROUTE;
            end
          end else begin
            err_id_n = 1'b1;
            drop_inc = 1'b1;
            if (!rx_end) state_n = DROP;
          end
        end
      end
      ROUTE: begin
        if (valid) begin
          if (len < LEN_W'(MAX_LEN)) begin
            ch_valid_n = N_CH'(1) << sel;
            ch_data_n  = i_data;
            len_n      = len + LEN_W'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end
        // rx_end is forwarded even after overflow so the reader's pointer resyncs.
        if (rx_end) begin
          ch_rx_end_n = N_CH'(1) << sel;
          state_n     = IDLE;
          ovf_n       = 1'b0;
          if (ovf || (valid && (len == LEN_W'(MAX_LEN)))) begin
            err_ovf_n = 1'b1;
            drop_inc  = 1'b1;
          end
        end else if (wd_expire) begin
          ch_rx_end_n = N_CH'(1) << sel;
          state_n     = IDLE;
          ovf_n       = 1'b0;
        end
      end
      DROP: begin
        if (rx_end || wd_expire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sel       <= '0;
      len       <= '0;
      ovf       <= 1'b0;
      ch_valid  <= '0;
      ch_rx_end <= '0;
      ch_data   <= '0;
      busy      <= 1'b0;
      err_id    <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      len       <= len_n;
      ovf       <= ovf_n;
      ch_valid  <= ch_valid_n;
      ch_rx_end <= ch_rx_end_n;
      ch_data   <= ch_data_n;
      busy      <= (state_n != IDLE);
      err_id    <= err_id_n;
      err_ovf   <= err_ovf_n;
    end
  end

  udp_sat_cnt #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .inc  (drop_inc),
    .q    (drop_cnt)
  );

endmodule

// File: doc/udp_rx_dispatch.md
Name: udp_rx_dispatch

Overview:
Routes one received UDP payload byte stream to one of N_CH downstream capture blocks, such as udp_reader instances. The first payload byte of each packet is a channel ID. The remaining bytes are forwarded to the selected channel, framed by that channel's own valid and rx_end strobes. The block sits between the UDP RX parser and the bank of per-function readers, so one RX stream serves several command/config consumers.

Parameters:
N_CH, 4, number of downstream channels (2..16); CH_W = $clog2(N_CH) is derived locally.
MAX_LEN, 64, maximum payload bytes forwarded per packet after the header byte.
TIMEOUT, 1024, idle cycles before a packet in progress is aborted (used only with the optional feature).

Ports:
clk  in  1  system clock, single clock domain.
rstn  in  1  asynchronous active-low reset.
valid  in  1  i_data holds a payload byte this cycle.
rx_end  in  1  single-cycle end-of-packet strobe; may coincide with the last valid.
i_data  in  8  payload byte.
ch_valid  out  N_CH  one-hot byte strobe to the selected channel.
ch_rx_end  out  N_CH  one-hot end-of-packet strobe to the selected channel.
ch_data  out  8  forwarded byte, shared by all channels.
busy  out  1  high while in ROUTE or DROP.
err_id  out  1  one-cycle pulse: header ID >= N_CH.
err_ovf  out  1  one-cycle pulse at end of a packet that exceeded MAX_LEN.
err_timeout  out  1  one-cycle pulse when the watchdog aborts a packet.
drop_cnt  out  16  saturating count of dropped packets (unknown ID or overflow).

Behaviour:
- Reset: all outputs 0, state IDLE, internal length counter 0, selected channel 0. Reset mid-packet discards the packet, and no rx_end is emitted.
- All outputs are registered. Forwarding latency is exactly 1 cycle from input to ch_*.
- FSM states: IDLE, ROUTE, DROP.
- IDLE, valid=1: the byte is the header and is not forwarded.
  - i_data < N_CH: latch sel=i_data[CH_W-1:0], len=0, go to ROUTE.
  - otherwise: pulse err_id, increment drop_cnt, go to DROP.
- IDLE, valid=1 and rx_end=1 together (header-only packet):
  - ID valid: pulse ch_rx_end[ID] next cycle, stay IDLE.
  - ID invalid: err_id, drop_cnt+1, stay IDLE.
- IDLE, rx_end alone: ignored.
- ROUTE, valid=1:
  - len < MAX_LEN: next cycle ch_valid[sel]=1, ch_data=i_data, len+1.
  - len == MAX_LEN: byte suppressed and the overflow flag set.
- ROUTE, rx_end=1: next cycle ch_rx_end[sel]=1, go to IDLE.
  - If valid also asserts, the last byte is forwarded and ch_valid[sel] and ch_rx_end[sel] assert in the same output cycle.
  - If the overflow flag is set: also pulse err_ovf and increment drop_cnt. rx_end is still forwarded so the downstream write pointer resynchronises.
  - The overflow flag clears on leaving ROUTE.
- DROP: consume bytes and emit nothing. rx_end returns to IDLE.
- ch_valid and ch_rx_end are never asserted on more than one channel at a time.
- ch_data holds its last value when ch_valid=0.
- busy reflects the state after the current cycle's transition.
- len is a counter of $clog2(MAX_LEN+1) bits and never wraps.
- drop_cnt saturates at 16'hFFFF.

Optional Feature:
Macro UDP_RX_DISPATCH_TIMEOUT_EN.
- Defined: a watchdog counts cycles in ROUTE or DROP with neither valid nor rx_end, and resets on either. When it reaches TIMEOUT:
  - force IDLE and pulse err_timeout;
  - from ROUTE, also pulse ch_rx_end[sel];
  - from DROP, emit no channel strobe.
  - Watchdog expiry and an input event in the same cycle: the input event wins.
- Not defined: no watchdog logic, err_timeout tied to 0, TIMEOUT ignored.

Decomposition:
- Package udp_rx_dispatch_pkg holds:
  - the state enum (IDLE, ROUTE, DROP);
  - DROP_CNT_W=16;
  - the header-ID width constant of 8.
- One sub-module is natural: udp_sat_cnt, a parameterised-width saturating incrementer with clear. It is used for drop_cnt and reused for the watchdog counter.

Test Plan:
- Packet {8'h01, 8'hA5, 8'h5A, rx_end with last} -> ch_valid[1] high 2 cycles with A5, 5A; ch_rx_end[1] coincident with the 5A cycle; other channels idle; busy low afterwards.
- Header 8'h07 with N_CH=4, then 3 bytes and rx_end -> err_id pulse on the header, no ch_* activity, drop_cnt=1.
- MAX_LEN=4, packet with header 8'h02 plus 6 bytes -> 4 ch_valid[2] strobes; ch_rx_end[2] plus err_ovf at end; drop_cnt+1.
- Header-only packet 8'h03 with valid and rx_end together -> single ch_rx_end[3] pulse, no ch_valid, state IDLE.
- rstn asserted mid-ROUTE after 2 bytes -> all outputs 0 immediately; next packet on channel 0 routes normally.
- With UDP_RX_DISPATCH_TIMEOUT_EN and TIMEOUT=16: header 8'h00 plus 1 byte then silence -> after 16 idle cycles, err_timeout and ch_rx_end[0] pulse; IDLE. Without the macro, err_timeout stays 0 and busy stays high.
